// File: rtl/cmp_pkg.sv
// Shared definitions for the SAR search initiator: state encoding,
// default operand width and a one-hot check on the comparator flags.
package cmp_pkg;

    localparam int CMP_WIDTH = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_PROBE = 1'b1
    } state_e;

    // A well-behaved comparator raises exactly one of gt/eq/lt.
    function automatic logic flags_onehot(input logic gt, input logic eq, input logic lt);
        return ({gt, eq, lt} == 3'b100) || ({gt, eq, lt} == 3'b010) ||
               ({gt, eq, lt} == 3'b001);
    endfunction

endpackage

// File: rtl/sar_next_guess.sv
// Combinational bound update for one binary-search step. Given the current
// window [lo, hi], the probe that was issued and the comparator verdict,
// produce the narrowed window, the next midpoint probe and a flag when the
// window cannot be narrowed any further (edge of range or empty window).
module sar_next_guess
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH
) (
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] guess_i,
    input  logic             gt_i,
    input  logic             eq_i,
    input  logic             lt_i,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] guess_o,
    output logic             bound_error_o
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] VMAX = '1;

    logic [WIDTH:0] sum;

    // Narrow the window; range edges are trapped before the +/-1 so the
    // bounds never wrap. Midpoint uses a WIDTH+1 bit sum to avoid overflow.
    always_comb begin
        lo_o          = lo_i;
        hi_o          = hi_i;
        bound_error_o = 1'b0;
        if (gt_i && !eq_i && !lt_i) begin
            if (guess_i == '0) begin
                bound_error_o = 1'b1;
            end else begin
                hi_o = guess_i - ONE;
                if (lo_i > hi_o) bound_error_o = 1'b1;
            end
        end else if (lt_i && !eq_i && !gt_i) begin
            if (guess_i == VMAX) begin
                bound_error_o = 1'b1;
            end else begin
                lo_o = guess_i + ONE;
                if (lo_o > hi_i) bound_error_o = 1'b1;
            end
        end
        sum     = {1'b0, lo_o} + {1'b0, hi_o};
        guess_o = sum[WIDTH:1];
    end

endmodule

// File: rtl/comparator_sar_search.sv
// Binary-search initiator for an external combinational magnitude
// comparator. Drives a registered probe on 'guess', samples the gt/eq/lt
// verdict one cycle later and converges on the comparator's B operand.
module comparator_sar_search
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] guess,
    input  logic             cmp_gt,
    input  logic             cmp_eq,
    input  logic             cmp_lt,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH:0]   probes
);

    localparam logic [WIDTH-1:0] VMAX      = '1;
    localparam logic [WIDTH-1:0] FIRST_MID = VMAX >> 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH:0]   probes_q, probes_d;
    logic             error_q, error_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] nxt_lo, nxt_hi, nxt_guess;
    logic             bound_err;

    sar_next_guess #(.WIDTH(WIDTH)) u_next (
        .lo_i          (lo_q),
        .hi_i          (hi_q),
        .guess_i       (guess_q),
        .gt_i          (cmp_gt),
        .eq_i          (cmp_eq),
        .lt_i          (cmp_lt),
        .lo_o          (nxt_lo),
        .hi_o          (nxt_hi),
        .guess_o       (nxt_guess),
        .bound_error_o (bound_err)
    );

    // Next-state and output-register logic; done defaults low so it pulses.
    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        guess_d  = guess_q;
        result_d = result_q;
        probes_d = probes_q;
        error_d  = error_q;
        done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    lo_d     = '0;
                    hi_d     = VMAX;
                    guess_d  = FIRST_MID;
                    probes_d = '0;
                    error_d  = 1'b0;
                    state_d  = ST_PROBE;
                end
            end
            ST_PROBE: begin
                probes_d = probes_q + 1'b1;
                if (!flags_onehot(cmp_gt, cmp_eq, cmp_lt)) begin
                    // Malformed verdict: report the probe that provoked it.
                    error_d  = 1'b1;
                    done_d   = 1'b1;
                    result_d = guess_q;
                    state_d  = ST_IDLE;
                end else if (cmp_eq) begin
                    result_d = guess_q;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else if (bound_err) begin
                    // Inconsistent comparator: window exhausted, result untouched.
                    error_d  = 1'b1;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    lo_d    = nxt_lo;
                    hi_d    = nxt_hi;
                    guess_d = nxt_guess;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            guess_q  <= '0;
            result_q <= '0;
            probes_q <= '0;
            error_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            probes_q <= probes_d;
            error_q  <= error_d;
            done_q   <= done_d;
        end
    end

    assign guess  = guess_q;
    assign busy   = (state_q == ST_PROBE);
    assign done   = done_q;
    assign error  = error_q;
    assign result = result_q;
    assign probes = probes_q;

endmodule

// File: tb/tb_comparator_sar_search.sv
// Scoreboard bench: stimulus predicts each search outcome with a simple
// integer binary-search model and queues it; a monitor checks on done.
module tb_comparator_sar_search;

    localparam int W   = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] guess, result;
    logic         cmp_gt, cmp_eq, cmp_lt;
    logic         busy, done, error;
    logic [W:0]   probes;

    logic [W-1:0] target = '0;
    logic         force_en = 1'b0;
    logic [2:0]   force_flags = 3'b000;

    always #5 clk = ~clk;

    comparator_sar_search #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .guess  (guess),
        .cmp_gt (cmp_gt),
        .cmp_eq (cmp_eq),
        .cmp_lt (cmp_lt),
        .busy   (busy),
        .done   (done),
        .error  (error),
        .result (result),
        .probes (probes)
    );

    // Responder: the 4-bit magnitude comparator with B = target, A = guess,
    // optionally overridden to emulate a broken comparator.
    assign {cmp_gt, cmp_eq, cmp_lt} = force_en ? force_flags
                                     : {guess > target, guess == target, guess < target};

    typedef struct {
        int res;
        int err;
        int nprb;
        int start_edge;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_result = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // mode 0: honest comparator; 1: flags 000; 2: flags 101; 3: always gt.
    function automatic void model(input int tgt, input int mode,
                                  output int res, output int err, output int n);
        int lo, hi, g;
        bit gt, eq, lt;
        lo = 0; hi = MAXV; n = 0; res = last_result; err = 0;
        for (int step = 0; step < 32; step++) begin
            g = (lo + hi) / 2;
            n++;
            case (mode)
                1: begin gt = 0; eq = 0; lt = 0; end
                2: begin gt = 1; eq = 0; lt = 1; end
                3: begin gt = 1; eq = 0; lt = 0; end
                default: begin gt = (g > tgt); eq = (g == tgt); lt = (g < tgt); end
            endcase
            if (int'(gt) + int'(eq) + int'(lt) != 1) begin err = 1; res = g; return; end
            if (eq) begin res = g; return; end
            if (gt) begin
                if (g == 0) begin err = 1; return; end
                hi = g - 1;
            end else begin
                if (g == MAXV) begin err = 1; return; end
                lo = g + 1;
            end
            if (lo > hi) begin err = 1; return; end
        end
    endfunction

    // Monitor: every done must match the oldest queued prediction.
    initial begin
        bit prev_done = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (prev_done) chk("done_one_cycle", int'(done), 0);
            if (!rst && done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("result", int'(result), e.res);
                    chk("error", int'(error), e.err);
                    chk("probes", int'(probes), e.nprb);
                    chk("latency_edges", cyc - e.start_edge + 1, e.nprb + 1);
                    chk("busy_at_done", int'(busy), 0);
                end
            end
            prev_done = done;
        end
    end

    // Issue a search from a negedge; returns at the negedge after done.
    task automatic run_search(input int tgt, input int mode, input bit dup);
        exp_t e;
        int k;
        model(tgt, mode, e.res, e.err, e.nprb);
        e.start_edge = cyc + 1;
        q.push_back(e);
        last_result = e.res;
        target   = W'(tgt);
        force_en = (mode != 0);
        case (mode)
            1: force_flags = 3'b000;
            2: force_flags = 3'b101;
            3: force_flags = 3'b100;
            default: force_flags = 3'b000;
        endcase
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (dup) begin
            @(negedge clk);
            chk("busy_before_dup", int'(busy), 1);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!done) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("idle_after_done", int'(busy), 0);
    endtask

    initial begin
        int t, m;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_guess", int'(guess), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_probes", int'(probes), 0);
        rst = 1'b0;
        @(negedge clk);

        run_search(7, 0, 0);
        run_search(0, 0, 0);
        run_search(15, 0, 0);
        run_search(9, 1, 0);
        run_search(9, 2, 0);
        run_search(12, 0, 0);
        run_search(4, 3, 0);

        // Reset during the second probe cycle of a search for 0.
        target = '0; force_en = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_probe1", int'(busy), 1);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        last_result = 0;
        chk("midrst_guess", int'(guess), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_error", int'(error), 0);
        chk("midrst_result", int'(result), 0);
        chk("midrst_probes", int'(probes), 0);
        @(negedge clk);
        chk("midrst_still_idle", int'(busy), 0);

        run_search(0, 0, 0);
        run_search(0, 0, 1);
        run_search(5, 0, 0);

        for (int i = 0; i < 40; i++) begin
            t = $urandom_range(MAXV, 0);
            m = ($urandom_range(9, 0) < 7) ? 0 : $urandom_range(3, 1);
            run_search(t, m, 0);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
